// File: rtl/ysyx_22041071_rd_arbiter_pkg.sv
// Shared constants for the IF/MEM AXI read arbiter: bus widths, AXI IDs and FSM encoding.
`ifndef YSYX_22041071_RD_ARBITER_DEFS
`define YSYX_22041071_RD_ARBITER_DEFS
`define ysyx_22041071_AXI_DATA_WIDTH 64
`define ysyx_22041071_ADDR_BUS 64
`define ysyx_22041071_RESP_TYPE_WIDTH 2
`endif

package ysyx_22041071_rd_arbiter_pkg;

    localparam int AXI_DATA_WIDTH  = `ysyx_22041071_AXI_DATA_WIDTH;
    localparam int ADDR_BUS        = `ysyx_22041071_ADDR_BUS;
    localparam int RESP_TYPE_WIDTH = `ysyx_22041071_RESP_TYPE_WIDTH;

    localparam logic       ID_IF     = 1'b0;
    localparam logic       ID_MEM    = 1'b1;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/ysyx_22041071_rd_arbiter_if.sv
// AXI read address/data channel bundle between the arbiter (master) and the bus (slave).
interface ysyx_22041071_rd_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RESP_W = 2
);
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic [2:0]        ar_size;
    logic              ar_id;
    logic              ar_ready;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [RESP_W-1:0] r_resp;
    logic              r_last;
    logic              r_id;
    logic              r_ready;

    modport master (
        output ar_valid, ar_addr, ar_size, ar_id, r_ready,
        input  ar_ready, r_valid, r_data, r_resp, r_last, r_id
    );

    modport slave (
        input  ar_valid, ar_addr, ar_size, ar_id, r_ready,
        output ar_ready, r_valid, r_data, r_resp, r_last, r_id
    );
endinterface

// File: rtl/ysyx_22041071_rr_grant2.sv
// Two-way round-robin picker: on a conflict the requester that did not win last time goes first.
module ysyx_22041071_rr_grant2
    import ysyx_22041071_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,         // [0] = IF, [1] = MEM
    input  logic       last_grant,  // AXI id of the previous owner
    output logic [1:0] grant        // one-hot, same bit order as req
);
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == ID_IF) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/ysyx_22041071_rd_arbiter.sv
// Shares one AXI read port between instruction fetch and data load, one transaction outstanding,
// round-robin on conflict, with IF flush that lets a fetch finish on the bus but never delivers it.
module ysyx_22041071_rd_arbiter
    import ysyx_22041071_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int DATA_W = AXI_DATA_WIDTH,
    parameter int RESP_W = RESP_TYPE_WIDTH
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_r_valid,
    output logic [DATA_W-1:0] if_r_data,
    output logic [ADDR_W-1:0] if_r_addr,
    output logic [RESP_W-1:0] if_r_resp,

    input  logic              mem_req_valid,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [2:0]        mem_req_size,
    output logic              mem_req_ready,
    output logic              mem_r_valid,
    output logic [DATA_W-1:0] mem_r_data,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [RESP_W-1:0] mem_r_resp,

    ysyx_22041071_rd_arbiter_if.master axi
);
    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              pend_id_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [2:0]        pend_size_q;
    logic              drop_q;
    logic              err_id;

    logic [1:0] grant;
    logic       accept;
    logic       beat_hit, beat_miss, beat_done;
    logic       route_if, route_mem;

    ysyx_22041071_rr_grant2 u_grant (
        .req        ({mem_req_valid, if_req_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept    = (state_q == S_IDLE) && (grant != 2'b00);
    assign beat_hit  = (state_q == S_DATA) && axi.r_valid && (axi.r_id == pend_id_q);
    assign beat_miss = (state_q == S_DATA) && axi.r_valid && (axi.r_id != pend_id_q);
    assign beat_done = beat_hit && axi.r_last;

    always_comb begin
        state_d       = state_q;
        if_req_ready  = 1'b0;
        mem_req_ready = 1'b0;
        axi.ar_valid  = 1'b0;
        axi.r_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if_req_ready  = grant[0];
                mem_req_ready = grant[1];
                if (accept) state_d = S_ADDR;
            end
            S_ADDR: begin
                axi.ar_valid = 1'b1;
                if (axi.ar_ready) state_d = S_DATA;
            end
            S_DATA: begin
                axi.r_ready = 1'b1;
                if (beat_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= ID_IF;
            pend_id_q    <= ID_IF;
            pend_addr_q  <= '0;
            pend_size_q  <= '0;
            drop_q       <= 1'b0;
            err_id       <= 1'b0;
        end else begin
            if (accept) begin
                pend_addr_q <= grant[1] ? mem_req_addr : if_req_addr;
                pend_size_q <= grant[1] ? mem_req_size : SIZE_WORD;
                pend_id_q   <= grant[1] ? ID_MEM : ID_IF;
            end
            if (beat_done) last_grant_q <= pend_id_q;
            if (beat_miss) err_id <= 1'b1;
            // A flush only matters while IF owns (or is just taking) the bus; drop ends with the burst.
            if (state_q == S_IDLE)                  drop_q <= accept && grant[0] && if_flush;
            else if (beat_done)                     drop_q <= 1'b0;
            else if (if_flush && pend_id_q == ID_IF) drop_q <= 1'b1;
        end
    end

    assign axi.ar_addr = pend_addr_q;
    assign axi.ar_size = pend_size_q;
    assign axi.ar_id   = pend_id_q;

    // Returns are combinational from R; a flush in the beat's own cycle also suppresses it.
    assign route_if  = beat_hit && (pend_id_q == ID_IF) && !drop_q && !if_flush;
    assign route_mem = beat_hit && (pend_id_q == ID_MEM);

    assign if_r_valid  = route_if;
    assign if_r_data   = route_if  ? axi.r_data : '0;
    assign if_r_addr   = route_if  ? pend_addr_q : '0;
    assign if_r_resp   = route_if  ? axi.r_resp : '0;
    assign mem_r_valid = route_mem;
    assign mem_r_data  = route_mem ? axi.r_data : '0;
    assign mem_r_addr  = route_mem ? pend_addr_q : '0;
    assign mem_r_resp  = route_mem ? axi.r_resp : '0;

    err_id_sticky: assert property (@(posedge clk) disable iff (reset) err_id |=> err_id);

endmodule

// File: doc/ysyx_22041071_rd_arbiter.md
# ysyx_22041071_rd_arbiter

Two-requester AXI read-channel arbiter that shares the core's single AXI master read port between instruction fetch (IF) and data load (MEM). It sits between the IF/MEM stages and the AXI master and allows one outstanding transaction. It uses round-robin grant on conflict. It supports IF-side flush, so that a fetch already issued on a taken branch or bubble completes on the bus but is never delivered to IF.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, AXI read data width
- RESP_W, 2, AXI response width

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- if_req_valid  in  1  IF fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  discard the in-flight or just-accepted IF fetch
- if_r_valid  out  1  fetch data valid
- if_r_data / if_r_addr / if_r_resp  out  DATA_W/ADDR_W/RESP_W  returned data, original address, response
- mem_req_valid  in  1  load request
- mem_req_addr  in  ADDR_W  load address
- mem_req_size  in  3  AXI size encoding
- mem_req_ready  out  1  load accepted
- mem_r_valid / mem_r_data / mem_r_addr / mem_r_resp  out  1/DATA_W/ADDR_W/RESP_W  load return
- ar_valid, ar_addr, ar_size, ar_id  out  1/ADDR_W/3/1  AXI AR channel; ar_id is 0 for IF, 1 for MEM
- ar_ready  in  1
- r_valid, r_data, r_resp, r_last, r_id  in  1/DATA_W/RESP_W/1/1  AXI R channel
- r_ready  out  1

## Operation
FSM states IDLE, ADDR, DATA, with reset to IDLE.
- **IDLE:** one grant per cycle. A single requester wins. When both request, the winner is the one that is not last_grant. last_grant resets to IF, so MEM wins the first conflict.
  - The winner's *_req_ready is 1 and is combinational from valid.
  - The address, size (3'b010 for IF) and id are registered into a pending register.
  - The state moves to ADDR.
- **ADDR:** ar_valid=1 with the registered fields held stable. On ar_ready the state moves to DATA. Fields must not change while ar_valid is 1 and ar_ready is 0.
- **DATA:** r_ready=1.
  - On r_valid with r_id equal to the pending id, the beat is routed to the owner's *_r_valid/data/resp, and *_r_addr is the pending address.
  - On r_last the state moves to IDLE, and last_grant is updated to the owner.
  - A beat with a mismatched r_id is consumed and dropped, and the sticky status bit err_id is set (internal, observable by the bench).
- **Flush:** a drop flag is set if if_flush is high while the pending owner is IF in ADDR or DATA, or in the IDLE cycle of IF acceptance. While drop is set, the transaction completes on AXI but if_r_valid stays 0. drop clears on return to IDLE.
  - if_flush with no IF transaction pending has no effect.
- *_req_ready is 0 outside IDLE, because only one transaction is outstanding.
- Non-OKAY r_resp is passed through unchanged and the arbiter takes no other action.

## Timing
- Reset values: all valid/ready outputs 0, ar_addr/ar_size/ar_id 0, *_r_data/addr/resp 0, state IDLE, last_grant IF, drop 0.
- Request accepted in cycle T: ar_valid is 1 from T+1.
- AR handshake in cycle A: the earliest R beat is accepted at A+1.
- Return outputs are combinational from the R channel (zero added latency). *_r_valid lasts exactly one cycle per beat.
- Last beat at cycle L: IDLE at L+1, and the next grant can be accepted at L+1.
- Best-case back-to-back single-beat reads accept one request every 3 cycles.
- Reset asserted in any state: IDLE on the next edge. The outstanding AXI transaction is abandoned, and the bench must not return stale beats after reset.
- if_flush in the same cycle as r_valid (IF owner): that beat is suppressed.

## Structure
- Shared package/`define file: state encodings, ID_IF=1'b0, ID_MEM=1'b1, SIZE_WORD=3'b010, and the existing ysyx_22041071_AXI_DATA_WIDTH / ADDR_BUS / RESP_TYPE_WIDTH macros.
- Natural sub-module: ysyx_22041071_rr_grant2, a 2-way round-robin picker taking two valids and last_grant and producing a one-hot grant.
- The FSM, pending registers and routing stay in the top module.

## Test plan
- **IF only:** if_req addr 0x8000_0000 → ar_addr 0x8000_0000, ar_id 0, ar_size 2. An R beat with data 0x1122_3344_5566_7788 gives if_r_valid for one cycle with that data and if_r_addr 0x8000_0000.
- **Simultaneous IF and MEM after reset:** MEM is granted first (ar_id 1) and IF is granted next. A second conflict then grants MEM again only after IF has been served.
- **AR backpressure:** ar_ready held 0 for 5 cycles → ar_valid stays 1 and ar_addr stays stable, with no *_req_ready during the stall.
- **Flush:** if_flush asserted in ADDR → AR is still issued, the R beat is consumed (r_ready=1), if_r_valid stays 0, and the next request is accepted the cycle after r_last.
- **Reset mid-DATA:** reset in DATA → all outputs return to their reset values on the next cycle, and the FSM is IDLE.
- **SLVERR:** r_resp=2'b10 on a MEM read → mem_r_resp=2'b10 and mem_r_valid=1, with no FSM hang.
